// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue
// Purpose  : RV32I decode and issue stage. Decodes opcode, func3, the ALU
//            variant bit and the immediates. Selects the two ALU operands and
//            the jump/branch target, then holds the result in a one-entry
//            ID/EX register with a valid/ready handshake, flush and an
//            issued-instruction counter.
// Ports    : clk, rst_n             - clock, asynchronous active-low reset
//            in_valid/in_ready      - fetch-side handshake (in_ready is comb)
//            instr, pc              - instruction word and its address
//            rs1_data, rs2_data     - register-file read data
//            flush                  - kill held entry and this cycle's input
//            out_valid/out_ready    - execute-side handshake
//            opcode, func3, func7   - decoded fields
//            operand1, operand2     - ALU operands
//            store_data, rd, target - store data, destination, branch target
//            illegal                - unsupported encoding flag
//            issue_count            - number of captured instructions
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [31:0] store_data,
  output logic [4:0]  rd,
  output logic [31:0] target,
  output logic        illegal,
  output logic [31:0] issue_count
);

  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  logic [4:0]  dec_opcode;
  logic [2:0]  dec_func3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] jalr_sum;
  logic        dec_func7;
  logic        dec_illegal;
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic [31:0] dec_target;
  logic [31:0] dec_store;
  logic        capture;

  assign dec_opcode = instr[6:2];
  assign dec_func3  = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign jalr_sum = rs1_data + imm_i;

  // func7 is only meaningful for register ALU ops and the shift-right
  // immediate form (SRLI/SRAI); every other encoding reports 0.
  assign dec_func7 = ((dec_opcode == OP_OP) ||
                      (dec_opcode == OP_OPIMM && dec_func3 == 3'b101)) ? instr[30] : 1'b0;

  always_comb begin
    dec_illegal = 1'b0;
    dec_op1     = 32'd0;
    dec_op2     = 32'd0;
    dec_target  = 32'd0;
    case (dec_opcode)
      OP_OP: begin
        dec_op1 = rs1_data;
        dec_op2 = rs2_data;
      end
      OP_OPIMM: begin
        dec_op1 = rs1_data;
        // Shift-immediates carry only a 5-bit shamt; the upper field holds func7.
        dec_op2 = (dec_func3[1:0] == 2'b01) ? {27'd0, instr[24:20]} : imm_i;
      end
      OP_LUI: begin
        dec_op2 = imm_u;
      end
      OP_AUIPC: begin
        dec_op1 = pc;
        dec_op2 = imm_u;
      end
      OP_LOAD: begin
        dec_op1 = rs1_data;
        dec_op2 = imm_i;
      end
      OP_STORE: begin
        dec_op1 = rs1_data;
        dec_op2 = imm_s;
      end
      OP_JAL: begin
        dec_op1    = pc;
        dec_target = pc + imm_j;
      end
      OP_JALR: begin
        dec_op1    = pc;
        dec_target = {jalr_sum[31:1], 1'b0};
      end
      OP_BRANCH: begin
        dec_op1    = rs1_data;
        dec_op2    = rs2_data;
        dec_target = pc + imm_b;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end
    // Illegal entries still issue but carry no data so execute cannot act on
    // stale operand values.
    if (dec_illegal) begin
      dec_op1    = 32'd0;
      dec_op2    = 32'd0;
      dec_target = 32'd0;
    end
  end

  assign dec_store = dec_illegal ? 32'd0 : rs2_data;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      opcode      <= 5'd0;
      func3       <= 3'd0;
      func7       <= 1'b0;
      operand1    <= 32'd0;
      operand2    <= 32'd0;
      store_data  <= 32'd0;
      rd          <= 5'd0;
      target      <= 32'd0;
      illegal     <= 1'b0;
      issue_count <= 32'd0;
    end else begin
      if (flush) begin
        // Payload is left as-is; only the valid bit is dropped.
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid   <= 1'b1;
        opcode      <= dec_opcode;
        func3       <= dec_func3;
        func7       <= dec_func7;
        operand1    <= dec_op1;
        operand2    <= dec_op2;
        store_data  <= dec_store;
        rd          <= instr[11:7];
        target      <= dec_target;
        illegal     <= dec_illegal;
        issue_count <= issue_count + 32'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
